// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: machine word, queue entry and the NOP encoding.
package fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } fetchq_entry_t;

  // sll $0,$0,0 encodes as all zeros
  localparam word_t NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle around the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 2
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic            ihit;
  word_t           imemload;
  word_t           imemaddr;
  word_t           npc_in;
  logic            pc_advance;
  logic            flush;
  logic            dec_ready;
  word_t           instr;
  word_t           pc_out;
  word_t           npc_out;
  logic            valid;
  logic            full;
  logic [CntW-1:0] count;

  modport master (
    output ihit, imemload, imemaddr, npc_in, flush, dec_ready,
    input  pc_advance, instr, pc_out, npc_out, valid, full, count
  );

  modport slave (
    input  ihit, imemload, imemaddr, npc_in, flush, dec_ready,
    output pc_advance, instr, pc_out, npc_out, valid, full, count
  );

  // PC unit view: pc_advance gates the nPC load
  modport pc (
    output ihit, imemload, imemaddr, npc_in,
    input  pc_advance
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; flush drops all held and incoming words.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input logic          clk_i,
  input logic          rst_ni,
  fetch_queue_if.slave fq_io
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetchq_entry_t   mem_q [Depth];
  fetchq_entry_t   head;

  logic valid, full, push, pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CntW'(Depth));
  assign pop   = valid & fq_io.dec_ready & ~fq_io.flush;
  // A full queue still accepts a word when the head leaves in the same cycle
  assign push  = fq_io.ihit & ~fq_io.flush & (~full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq_io.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: fq_io.imemload, pc: fq_io.imemaddr, npc: fq_io.npc_in};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign fq_io.pc_advance = push;
  assign fq_io.instr      = valid ? head.instr : NOP_INSTR;
  assign fq_io.pc_out     = valid ? head.pc    : '0;
  assign fq_io.npc_out    = valid ? head.npc   : '0;
  assign fq_io.valid      = valid;
  assign fq_io.full       = full;
  assign fq_io.count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected words, a negedge monitor checks the head.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned Depth = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  bit   started;

  fetchq_entry_t exp_q[$];

  fetch_queue_if #(.Depth(Depth)) bus ();

  fetch_queue #(.Depth(Depth)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .fq_io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then retire the head if decode takes it
  always @(negedge clk) begin
    if (rst_n && started) begin
      check("count", 32'(bus.count), 32'(exp_q.size()));
      check("valid", 32'(bus.valid), 32'(exp_q.size() != 0));
      check("full", 32'(bus.full), 32'(exp_q.size() == Depth));
      if (exp_q.size() == 0) begin
        check("instr_empty", bus.instr, NOP_INSTR);
        check("pc_empty", bus.pc_out, 32'h0);
        check("npc_empty", bus.npc_out, 32'h0);
      end else begin
        check("instr", bus.instr, exp_q[0].instr);
        check("pc_out", bus.pc_out, exp_q[0].pc);
        check("npc_out", bus.npc_out, exp_q[0].npc);
        if (bus.dec_ready && !bus.flush) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus with a hand-computed expected pc_advance
  task automatic step(input logic ih, input word_t w, input word_t pc, input logic dr,
                      input logic fl, input logic exp_adv);
    bus.ihit      = ih;
    bus.imemload  = w;
    bus.imemaddr  = pc;
    bus.npc_in    = pc + 32'd4;
    bus.dec_ready = dr;
    bus.flush     = fl;
    @(negedge clk);
    check("pc_advance", 32'(bus.pc_advance), 32'(exp_adv));
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (exp_adv) exp_q.push_back('{instr: w, pc: pc, npc: pc + 32'd4});
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 32'h0, 32'h0, dr, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    started  = 1'b0;
    rst_n    = 1'b0;
    bus.ihit = 1'b0;
    bus.imemload = '0;
    bus.imemaddr = '0;
    bus.npc_in = '0;
    bus.dec_ready = 1'b0;
    bus.flush = 1'b0;
    #2;
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_advance", 32'(bus.pc_advance), 32'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b1;

    // Test 1: async reset mid-run drops the held word immediately
    step(1'b1, 32'h1111_0000, 32'h100, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.valid), 32'h0);
    check("async_rst_count", 32'(bus.count), 32'h0);
    check("async_rst_instr", bus.instr, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b1);

    // Test 2: fill with decode stalled; third word is refused
    step(1'b1, 32'hA000_0000, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA000_0001, 32'h4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA000_0002, 32'h8, 1'b0, 1'b0, 1'b0);
    check("fill_full", 32'(bus.full), 32'h1);
    check("fill_head_pc", bus.pc_out, 32'h0);
    check("fill_head_npc", bus.npc_out, 32'h4);

    // Test 3: full queue accepts A2 while A0 leaves
    step(1'b1, 32'hA000_0002, 32'h8, 1'b1, 1'b0, 1'b1);
    check("pp_count", 32'(bus.count), 32'h2);
    check("pp_head", bus.instr, 32'hA000_0001);

    // Test 4: streaming six words wraps the pointers; then drain
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hC000_0000 + 32'(i), 32'h40 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);
    check("drain_empty", 32'(bus.valid), 32'h0);

    // Test 5: flush with ihit and dec_ready drops everything
    step(1'b1, 32'hD000_0000, 32'h200, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hD000_0001, 32'h204, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hD000_0002, 32'h208, 1'b1, 1'b1, 1'b0);
    check("flush_valid", 32'(bus.valid), 32'h0);
    check("flush_count", 32'(bus.count), 32'h0);
    step(1'b1, 32'hE000_0000, 32'h300, 1'b0, 1'b0, 1'b1);
    check("post_flush_head", bus.instr, 32'hE000_0000);
    check("post_flush_pc", bus.pc_out, 32'h300);

    // Flush while empty
    idle(1'b1);
    step(1'b1, 32'hE000_0004, 32'h304, 1'b1, 1'b1, 1'b0);

    // Test 6: pop on empty queue is ignored
    idle(1'b1);
    idle(1'b1);
    check("empty_pop_count", 32'(bus.count), 32'h0);
    check("empty_pop_instr", bus.instr, 32'h0);
    check("model_drained", 32'(exp_q.size()), 32'h0);

    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
